// File: rtl/pc_unit.sv
// Program counter with kernel-mode bit, branch/jump/vector selection,
// synchronized level interrupt with a one-bit pending flag, and retire counter.
module pc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        BrTaken,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  input  logic        Stall,
  input  logic        IRQ,
  output logic [31:0] PC,
  output logic [31:0] NewPC,
  output logic        IRQTaken,
  output logic [31:0] EPC,
  output logic [31:0] InstCount
);

  localparam logic [31:0] BOOT_VEC    = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXCEPT_VEC  = 32'h8000_0008;

  logic        irq_s1;
  logic        irq_s2;
  logic        irq_prev;
  logic        irq_rise;
  logic        pending;
  logic        pending_next;
  logic [31:0] sel_pc;
  logic [31:0] next_pc;

  // The kernel bit never comes from the branch target, and jr targets are word aligned.
  logic unused_bits;
  assign unused_bits = ^{ConBA[31], DataBusA[1:0]};

  assign NewPC    = {PC[31], PC[30:0] + 31'd4};
  assign irq_rise = irq_s2 & ~irq_prev;
  assign IRQTaken = ~reset & pending & ~PC[31] & ~Stall;

  always_comb begin
    sel_pc = NewPC;
    unique case (PCSrc)
      3'b000:  sel_pc = NewPC;
      3'b001:  sel_pc = BrTaken ? {PC[31], ConBA[30:0]} : NewPC;
      3'b010:  sel_pc = {PC[31:28], JT, 2'b00};
      3'b011:  sel_pc = {DataBusA[31:2], 2'b00};
      3'b100:  sel_pc = ILLOP_VEC;
      3'b101:  sel_pc = EXCEPT_VEC;
      default: sel_pc = NewPC;
    endcase
  end

  always_comb begin
    next_pc = sel_pc;
    if (IRQTaken) begin
      next_pc = ILLOP_VEC;
    end
  end

  // A new edge wins over the clear from acceptance; the flag never counts.
  always_comb begin
    pending_next = pending;
    if (irq_rise) begin
      pending_next = 1'b1;
    end else if (IRQTaken) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1   <= 1'b0;
      irq_s2   <= 1'b0;
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_s1   <= IRQ;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
      pending  <= pending_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC        <= BOOT_VEC;
      EPC       <= 32'h0;
      InstCount <= 32'h0;
    end else if (!Stall) begin
      PC <= next_pc;
      if (IRQTaken) begin
        EPC <= PC;
      end else begin
        InstCount <= InstCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: next-PC selection, kernel bit, interrupt
// acceptance with stall and kernel masking, and reset behaviour.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        BrTaken;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DataBusA;
  logic        Stall;
  logic        IRQ;
  logic [31:0] PC;
  logic [31:0] NewPC;
  logic        IRQTaken;
  logic [31:0] EPC;
  logic [31:0] InstCount;

  int          total;
  int          bad;
  logic [31:0] exp_cnt;
  logic        irq_exp;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .PCSrc     (PCSrc),
    .BrTaken   (BrTaken),
    .ConBA     (ConBA),
    .JT        (JT),
    .DataBusA  (DataBusA),
    .Stall     (Stall),
    .IRQ       (IRQ),
    .PC        (PC),
    .NewPC     (NewPC),
    .IRQTaken  (IRQTaken),
    .EPC       (EPC),
    .InstCount (InstCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; the expected retire count follows the bench's own view.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset && !Stall && !irq_exp) exp_cnt++;
      #1;
    end
  endtask

  task automatic jr(input logic [31:0] target);
    PCSrc    = 3'b011;
    DataBusA = target;
    tick(1);
    PCSrc    = 3'b000;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    exp_cnt  = 32'h0;
    irq_exp  = 1'b0;
    reset    = 1'b1;
    PCSrc    = 3'b000;
    BrTaken  = 1'b0;
    ConBA    = 32'h0;
    JT       = 26'h0;
    DataBusA = 32'h0;
    Stall    = 1'b0;
    IRQ      = 1'b0;

    #12;
    check("rst_pc", PC, 32'h8000_0000);
    check("rst_newpc", NewPC, 32'h8000_0004);
    check("rst_epc", EPC, 32'h0);
    check("rst_cnt", InstCount, 32'h0);
    check("rst_irqtaken", {31'h0, IRQTaken}, 32'h0);

    // Sequential fetch from the boot vector.
    reset = 1'b0;
    check("seq_pc0", PC, 32'h8000_0000);
    tick(1);
    check("seq_pc1", PC, 32'h8000_0004);
    tick(1);
    check("seq_pc2", PC, 32'h8000_0008);
    tick(1);
    check("seq_cnt3", InstCount, 32'd3);

    // Conditional branch, not taken then taken.
    jr(32'h0040_0010);
    check("jr_user", PC, 32'h0040_0010);
    PCSrc = 3'b001; ConBA = 32'h0040_0100; BrTaken = 1'b0;
    tick(1);
    check("br_not_taken", PC, 32'h0040_0014);
    BrTaken = 1'b1;
    tick(1);
    check("br_taken", PC, 32'h0040_0100);
    BrTaken = 1'b0;

    // jr from kernel clears the kernel bit and drops the low address bits.
    jr(32'h8000_0020);
    check("jr_kernel", PC, 32'h8000_0020);
    jr(32'h0040_0203);
    check("jr_clear_kbit", PC, 32'h0040_0200);

    // Jump keeps the upper nibble including the kernel bit.
    jr(32'h8000_0040);
    PCSrc = 3'b010; JT = 26'h000_0100;
    tick(1);
    check("j_keep_kbit", PC, 32'h8000_0400);

    // Low 31-bit wrap leaves the kernel bit alone.
    jr(32'h7FFF_FFFC);
    check("wrap_user_newpc", NewPC, 32'h0000_0000);
    tick(1);
    check("wrap_user_pc", PC, 32'h0000_0000);
    jr(32'hFFFF_FFFC);
    check("wrap_kernel_newpc", NewPC, 32'h8000_0000);

    // Vectors and the reserved selects.
    PCSrc = 3'b100; tick(1);
    check("vec_illop", PC, 32'h8000_0004);
    PCSrc = 3'b101; tick(1);
    check("vec_except", PC, 32'h8000_0008);
    PCSrc = 3'b110; tick(1);
    check("sel_110", PC, 32'h8000_000C);
    PCSrc = 3'b111; tick(1);
    check("sel_111", PC, 32'h8000_0010);
    PCSrc = 3'b000;
    check("cnt_mid", InstCount, exp_cnt);

    // Interrupt raised in kernel mode is held until user mode.
    IRQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("irq_kernel_masked", {31'h0, IRQTaken}, 32'h0);
      tick(1);
    end
    check("irq_kernel_pc", PC, 32'h8000_0020);
    jr(32'h0040_0000);
    check("irq_user_pc", PC, 32'h0040_0000);
    check("irq_accept", {31'h0, IRQTaken}, 32'h1);
    irq_exp = 1'b1;
    tick(1);
    irq_exp = 1'b0;
    check("irq_vec_pc", PC, 32'h8000_0004);
    check("irq_epc", EPC, 32'h0040_0000);
    check("irq_cnt_held", InstCount, exp_cnt);
    check("irq_cleared", {31'h0, IRQTaken}, 32'h0);
    IRQ = 1'b0;
    tick(3);

    // Interrupt edge during a stall is pended, then accepted when the stall lifts.
    jr(32'h0040_0008);
    check("stall_entry_no_irq", {31'h0, IRQTaken}, 32'h0);
    Stall = 1'b1;
    IRQ   = 1'b1;
    tick(4);
    check("stall_pc_hold", PC, 32'h0040_0008);
    check("stall_cnt_hold", InstCount, exp_cnt);
    check("stall_no_accept", {31'h0, IRQTaken}, 32'h0);
    Stall = 1'b0;
    #1;
    check("stall_release_accept", {31'h0, IRQTaken}, 32'h1);
    irq_exp = 1'b1;
    tick(1);
    irq_exp = 1'b0;
    check("stall_epc", EPC, 32'h0040_0008);
    check("stall_vec_pc", PC, 32'h8000_0004);
    IRQ = 1'b0;
    tick(3);

    // Pend an interrupt in kernel mode, then reset mid-cycle.
    IRQ = 1'b1;
    tick(4);
    check("pend_kernel_masked", {31'h0, IRQTaken}, 32'h0);
    IRQ = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = 32'h0;
    check("async_rst_pc", PC, 32'h8000_0000);
    check("async_rst_epc", EPC, 32'h0);
    check("async_rst_cnt", InstCount, 32'h0);
    check("async_rst_irqtaken", {31'h0, IRQTaken}, 32'h0);
    PCSrc    = 3'b011;
    DataBusA = 32'h0040_0000;
    tick(2);
    check("rst_ignores_pcsrc", PC, 32'h8000_0000);
    reset = 1'b0;
    check("first_fetch", PC, 32'h8000_0000);
    tick(1);
    PCSrc = 3'b000;
    check("post_rst_user_pc", PC, 32'h0040_0000);
    check("pending_discarded", {31'h0, IRQTaken}, 32'h0);
    tick(1);
    check("post_rst_no_irq", {31'h0, IRQTaken}, 32'h0);
    check("post_rst_pc", PC, 32'h0040_0004);
    check("post_rst_cnt", InstCount, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset, named clk and reset; all state SHALL be cleared on reset assertion without waiting for a clock edge.
REQ-002 The block SHALL have the following ports; clock and reset are listed first:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- PCSrc  in  3  next-PC select from Control
- BrTaken  in  1  branch condition, ALU result bit 0
- ConBA  in  32  branch target
- JT  in  26  jump target field
- DataBusA  in  32  register rs value, jr/jalr target
- Stall  in  1  hold the fetch stage this cycle
- IRQ  in  1  external interrupt, asynchronous, level
- PC  out  32  current instruction address, to ROM/decode
- NewPC  out  32  PC+4 with the kernel bit preserved
- IRQTaken  out  1  interrupt accepted this cycle; downstream squashes the current instruction's RegWr/MemWr
- EPC  out  32  address of the instruction interrupted by the last accepted IRQ
- InstCount  out  32  retired-instruction counter

Function
REQ-003 NewPC SHALL equal {PC[31], PC[30:0]+4} combinationally; the PC[30:0] wrap from 0x7FFFFFFC SHALL yield 0x00000000 with PC[31] unchanged.
REQ-004 The next PC SHALL be selected by PCSrc:
- 000: NewPC
- 001: ConBA if BrTaken=1, else NewPC
- 010: {PC[31:28], JT, 2'b00}
- 011: {DataBusA[31:2], 2'b00}
- 100: 0x80000004 (illegal-op vector)
- 101: 0x80000008 (exception vector)
- 110 and 111: NewPC
REQ-005 PC[31] SHALL be the kernel-mode bit; only PCSrc=011, vector entry, or reset SHALL change it.
REQ-006 IRQ SHALL pass through a two-flop synchronizer; a rising edge of the synchronized signal SHALL set a pending flag.
REQ-007 An IRQ SHALL be accepted in a cycle where pending=1, PC[31]=0 and Stall=0.
REQ-008 On acceptance, in the same cycle:
- IRQTaken=1 combinationally
- next PC = 0x80000004
- EPC loads the current PC on the clock edge
- pending clears on the clock edge
REQ-009 Interrupt acceptance SHALL override PCSrc.
REQ-010 While PC[31]=1, pending SHALL be held and not accepted; it SHALL be accepted in the first user-mode, non-stalled cycle.
REQ-011 A new synchronized rising edge while pending=1 SHALL be absorbed; pending is one bit and does not count.
REQ-012 If an edge arrives in the same cycle that pending clears, set SHALL win and pending SHALL remain 1.
REQ-013 While Stall=1:
- PC, EPC and InstCount hold
- IRQTaken=0
- pending may still be set
REQ-014 InstCount SHALL increment by 1, modulo 2^32, on every edge with Stall=0 and IRQTaken=0.
REQ-015 Every PC change SHALL occur one clock edge after the selecting inputs are sampled; there is no added latency.

Reset
REQ-016 Reset SHALL force the following values:
- PC=0x80000000 (kernel boot)
- EPC=0
- InstCount=0
- pending=0
- both synchronizer flops=0
REQ-017 IRQTaken SHALL read 0 during reset.
REQ-018 Reset asserted mid-operation SHALL discard any pending interrupt and any in-flight PCSrc selection.
REQ-019 After reset deasserts, the first fetch SHALL be from 0x80000000.

Verification
REQ-020 Reset release, PCSrc=000, Stall=0 for 3 cycles -> PC sequence 0x80000000, 0x80000004, 0x80000008; InstCount=3.
REQ-021 PC=0x00400010, PCSrc=001, ConBA=0x00400100, BrTaken=0, then the same with BrTaken=1 -> PC=0x00400014, then next PC=0x00400100.
REQ-022 PC=0x80000020, PCSrc=011, DataBusA=0x00400203 -> PC=0x00400200, kernel bit cleared.
REQ-023 PC=0x80000040, PCSrc=010, JT=0x0000100 -> PC=0x80000400, kernel bit kept.
REQ-024 IRQ raised while PC=0x80000010, then jr to 0x00400000 -> no acceptance in kernel mode; acceptance in the first cycle at 0x00400000: IRQTaken=1, EPC=0x00400000, next PC=0x80000004, InstCount not incremented.
REQ-025 IRQ edge during Stall=1 at user PC 0x00400008 -> pending set, no acceptance; first cycle with Stall=0 gives IRQTaken=1 and EPC=0x00400008; reset asserted with pending=1 clears it and IRQTaken stays 0.
